bist_ctrl_param: RTL and testbench
==================================

Name: bist_ctrl_param

Overview:
Parametrised BIST controller for the circular-BIST test chip. It is the successor to the fixed 4-bit-LFSR / 8-bit-signature harness now driving the arbiter CUT.
- An LFSR of configurable width drives the CUT inputs.
- A configurable-width MISR compacts the CUT outputs over a runtime-programmable test length.
- The controller compensates for CUT pipeline latency and compares against a golden signature.
- Supports abort and repeated runs without reset.
- Sits between the top-level test pins and the CUT; in functional mode the CUT sees `func_in` unchanged.

Parameters:
- IN_W, 4, LFSR/pattern width (≥2)
- OUT_W, 4, CUT response width (≤ SIG_W)
- SIG_W, 8, MISR/signature width (≥2)
- LFSR_TAPS, 4'b1100, LFSR feedback tap mask, IN_W bits (x^4+x^3+1)
- MISR_TAPS, 8'hB8, MISR feedback tap mask, SIG_W bits
- CNT_W, 16, test-length counter width
- CUT_LAT, 0, CUT input-to-output latency in cycles (0..15)

Ports:
- clock, in, 1, system clock, rising edge
- reset, in, 1, asynchronous active-high reset
- bist_start, in, 1, level; rising edge (sampled) starts a run
- bist_abort, in, 1, synchronous abort, any state → IDLE
- lfsr_seed, in, IN_W, seed loaded at INIT
- test_len, in, CNT_W, number of patterns applied; sampled at INIT
- golden_sig, in, SIG_W, expected signature; sampled at COMPARE
- func_in, in, IN_W, functional inputs, passed through when not in BIST
- cut_out, in, OUT_W, CUT response
- cut_in, out, IN_W, CUT stimulus
- bist_busy, out, 1, high in INIT/RUN/FLUSH/COMPARE
- bist_end, out, 1, high in DONE
- pass_fail, out, 1, 1 = signature matched; valid while bist_end
- signature_out, out, SIG_W, MISR contents; frozen in DONE

Behaviour:
Reset (async, reset=1):
- state=IDLE; lfsr=all-ones; misr=0; counters=0.
- bist_busy=0, bist_end=0, pass_fail=0, signature_out=0.
- Start-edge register=0.

Start detection:
- start_p = bist_start & ~bist_start_q, both sampled on clock.
- A level held high does not retrigger.
- start_p is honoured only in IDLE or DONE.

Mux:
- cut_in = lfsr in RUN and FLUSH; otherwise cut_in = func_in (combinational).

FSM:
- IDLE: start_p → INIT.
- INIT (1 cycle):
  - lfsr ← lfsr_seed, or all-ones if lfsr_seed==0 (lockup guard).
  - misr ← 0; cnt ← 0; len_q ← test_len.
  - If test_len==0, go directly to COMPARE with misr=0; else → RUN.
- RUN (len_q cycles):
  - Each cycle lfsr ← {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}; cnt++.
  - The MISR compacts only once cnt ≥ CUT_LAT.
  - When cnt == len_q-1: → FLUSH if CUT_LAT>0, else → COMPARE.
- FLUSH (CUT_LAT cycles): lfsr holds; MISR keeps compacting. Total compaction cycles = len_q exactly.
- MISR update: misr ← {misr[SIG_W-2:0], ^(misr & MISR_TAPS)} ^ zero-extended cut_out.
- COMPARE (1 cycle): pass_fail ← (misr == golden_sig); signature_out ← misr; → DONE.
- DONE:
  - bist_end=1; outputs held.
  - start_p → INIT, and bist_end drops on the same edge.
- Latency: bist_end rises len_q + CUT_LAT + 2 cycles after the edge that sampled start_p.

Abort:
- bist_abort=1 in any non-IDLE state → IDLE next edge; pass_fail ← 0; bist_end ← 0; signature_out keeps its last value.
- Abort has priority over start_p.

Reset mid-run: immediate return to reset values; no partial bist_end.

Width rules:
- cnt wraps never; len_q ≤ 2^CNT_W-1.
- The LFSR repeats with period 2^IN_W-1 for primitive taps; test_len beyond the period is legal.

Test Plan:
1. Seed 4'hF, test_len=5, CUT_LAT=0, cut_out=cut_in loopback → cut_in during RUN = F,E,C,8,1; bist_end 7 cycles after start edge; signature matches bench model.
2. Seed 0 → first RUN pattern 4'hF (lockup guard); seed 4'hF, test_len=16 → pattern 16 == pattern 1 (period 15).
3. golden_sig = model signature → pass_fail=1; golden_sig ^ 8'h01 → pass_fail=0; single-bit stuck-at-0 injected on cut_out[2] → pass_fail=0.
4. CUT_LAT=2, test_len=10, 2-stage delayed loopback → exactly 10 compaction cycles; bist_end 14 cycles after start; signature equals CUT_LAT=0 undelayed run.
5. Abort asserted in RUN cycle 3 → IDLE next cycle, bist_end=0, pass_fail=0; a new start edge then gives a signature identical to a clean run.
6. bist_start held high across DONE → no retrigger; 5 back-to-back runs via toggled start with seed 4'hF → identical signatures; test_len=0 → bist_end after 2 cycles, signature_out=0.

Source files
------------

// File: rtl/bist_ctrl_param.sv
// Parametrised BIST controller: LFSR stimulus, MISR compaction, golden compare.
// Ports: clock/reset, bist_start/bist_abort control, lfsr_seed/test_len/golden_sig
//   setup, func_in/cut_in/cut_out CUT path, bist_busy/bist_end/pass_fail/signature_out status.
module bist_ctrl_param #(
  parameter int IN_W = 4,
  parameter int OUT_W = 4,
  parameter int SIG_W = 8,
  parameter logic [IN_W-1:0] LFSR_TAPS = 4'b1100,
  parameter logic [SIG_W-1:0] MISR_TAPS = 8'hB8,
  parameter int CNT_W = 16,
  parameter int CUT_LAT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bist_start,
  input  logic             bist_abort,
  input  logic [IN_W-1:0]  lfsr_seed,
  input  logic [CNT_W-1:0] test_len,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic [IN_W-1:0]  func_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic [IN_W-1:0]  cut_in,
  output logic             bist_busy,
  output logic             bist_end,
  output logic             pass_fail,
  output logic [SIG_W-1:0] signature_out
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    COMPARE,
    DONE
  } state_e;

  // One extra counter bit so RUN + FLUSH never wraps.
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] LAT_C = (CNT_W+1)'(CUT_LAT);
  localparam bit HAS_LAT = (CUT_LAT > 0);

  state_e state_q, state_d;
  logic start_q;
  logic [IN_W-1:0] lfsr_q, lfsr_d;
  logic [SIG_W-1:0] misr_q, misr_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic pf_q, pf_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic start_p;
  logic [IN_W-1:0] lfsr_step;
  logic [SIG_W-1:0] misr_step;
  logic [CNT_W:0] len_ext;
  logic [CNT_W:0] cnt_inc;
  logic compact;
  logic run_last;
  logic flush_last;

  assign start_p = bist_start & ~start_q;

  assign lfsr_step = {lfsr_q[IN_W-2:0],
                      ^(lfsr_q & LFSR_TAPS)};
  assign misr_step = {misr_q[SIG_W-2:0],
                      ^(misr_q & MISR_TAPS)}
                     ^ SIG_W'(cut_out);

  assign len_ext = {1'b0, len_q};
  assign cnt_inc = cnt_q + ONE;
  // Responses lag stimulus by CUT_LAT, so skip the first CUT_LAT
  // cycles and keep compacting through FLUSH: exactly len_q updates.
  assign compact = (cnt_q >= LAT_C);
  assign run_last = (cnt_inc == len_ext);
  assign flush_last = (cnt_inc == len_ext + LAT_C);

  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    pf_d = pf_q;
    sig_d = sig_q;
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = INIT;
      end
      INIT: begin
        // An all-zero seed would lock the LFSR.
        lfsr_d = (lfsr_seed == '0) ? '1 : lfsr_seed;
        misr_d = '0;
        cnt_d = '0;
        len_d = test_len;
        pf_d = 1'b0;
        state_d = (test_len == '0) ? COMPARE : RUN;
      end
      RUN: begin
        lfsr_d = lfsr_step;
        cnt_d = cnt_inc;
        if (compact) misr_d = misr_step;
        if (run_last) state_d = HAS_LAT ? FLUSH : COMPARE;
      end
      FLUSH: begin
        cnt_d = cnt_inc;
        if (compact) misr_d = misr_step;
        if (flush_last) state_d = COMPARE;
      end
      COMPARE: begin
        pf_d = (misr_q == golden_sig);
        sig_d = misr_q;
        state_d = DONE;
      end
      DONE: begin
        if (start_p) state_d = INIT;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start in DONE.
    if (bist_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      pf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      lfsr_q <= '1;
      misr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      pf_q <= 1'b0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bist_start;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      pf_q <= pf_d;
      sig_q <= sig_d;
    end
  end

  assign cut_in = ((state_q == RUN) || (state_q == FLUSH))
                  ? lfsr_q : func_in;
  assign bist_busy = (state_q == INIT) || (state_q == RUN) ||
                     (state_q == FLUSH) || (state_q == COMPARE);
  assign bist_end = (state_q == DONE);
  assign pass_fail = pf_q;
  assign signature_out = sig_q;

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Bench for bist_ctrl_param: two instances (CUT_LAT 0 and 2) with loopback CUTs.
// Expected patterns/signatures come from a bench LFSR/MISR model via queues.
module tb_bist_ctrl_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic bist_start, bist_abort;
  logic [3:0] lfsr_seed, func_in;
  logic [15:0] test_len;
  logic [7:0] golden_sig;
  logic [3:0] stuck;

  logic [3:0] cut_in0, cut_out0, cut_in1, cut_out1, d1, d2;
  logic busy0, end0, pf0, busy1, end1, pf1;
  logic [7:0] sig0, sig1;

  assign cut_out0 = cut_in0 & ~stuck;
  always @(posedge clk) begin
    d1 <= cut_in1;
    d2 <= d1;
  end
  assign cut_out1 = d2;

  bist_ctrl_param u0 (
    .clock(clk), .reset(rst),
    .bist_start(bist_start), .bist_abort(bist_abort),
    .lfsr_seed(lfsr_seed), .test_len(test_len),
    .golden_sig(golden_sig), .func_in(func_in),
    .cut_out(cut_out0), .cut_in(cut_in0),
    .bist_busy(busy0), .bist_end(end0),
    .pass_fail(pf0), .signature_out(sig0)
  );

  bist_ctrl_param #(.CUT_LAT(2)) u1 (
    .clock(clk), .reset(rst),
    .bist_start(bist_start), .bist_abort(bist_abort),
    .lfsr_seed(lfsr_seed), .test_len(test_len),
    .golden_sig(golden_sig), .func_in(func_in),
    .cut_out(cut_out1), .cut_in(cut_in1),
    .bist_busy(busy1), .bist_end(end1),
    .pass_fail(pf1), .signature_out(sig1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_sig_q[$];
  logic [3:0] exp_pat_q[$];
  logic [3:0] obs_q[$];
  int cyc0, cyc1;
  bit to;

  function automatic logic [3:0] m_lfsr(logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [7:0] m_misr(logic [7:0] m, logic [3:0] d);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {4'h0, d};
  endfunction

  function automatic logic [3:0] m_pat(logic [3:0] seed, int i);
    logic [3:0] s;
    s = (seed == 4'h0) ? 4'hF : seed;
    for (int k = 0; k < i; k++) s = m_lfsr(s);
    return s;
  endfunction

  function automatic logic [7:0] m_sig(logic [3:0] seed, int len,
                                       logic [3:0] mask);
    logic [3:0] s;
    logic [7:0] m;
    s = (seed == 4'h0) ? 4'hF : seed;
    m = 8'h00;
    for (int k = 0; k < len; k++) begin
      m = m_misr(m, s & ~mask);
      s = m_lfsr(s);
    end
    return m;
  endfunction

  // Raise start, then count edges until both instances reach DONE.
  task automatic do_run(input int maxc);
    obs_q.delete();
    cyc0 = 0;
    cyc1 = 0;
    to = 1'b0;
    @(negedge clk) bist_start = 1'b0;
    @(negedge clk) bist_start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (busy0 && cut_in0 != 4'h0) obs_q.push_back(cut_in0);
      if (end0 && cyc0 == 0) cyc0 = i;
      if (end1 && cyc1 == 0) cyc1 = i;
      if (cyc0 != 0 && cyc1 != 0) break;
    end
    if (cyc0 == 0 || cyc1 == 0) to = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] e;
    rst = 1'b1;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    lfsr_seed = 4'hF;
    test_len = 16'd5;
    golden_sig = 8'h00;
    func_in = 4'hA;
    stuck = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy0, end0, pf0} !== 3'b000)
      $display("FAIL reset_flags got=%b want=000", {busy0, end0, pf0});
    else pass_cnt++;
    e = 8'h00;
    total_cnt++;
    if (sig0 !== e)
      $display("FAIL reset_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (cut_in0 !== 4'hA)
      $display("FAIL reset_passthru got=%h want=a", cut_in0);
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    func_in = 4'h0;
  endtask

  task automatic test_basic;
    logic [7:0] e;
    logic [3:0] p, o;
    lfsr_seed = 4'hF;
    test_len = 16'd5;
    golden_sig = m_sig(4'hF, 5, 4'h0);
    exp_sig_q.push_back(m_sig(4'hF, 5, 4'h0));
    exp_pat_q.push_back(4'hF);
    exp_pat_q.push_back(4'hE);
    exp_pat_q.push_back(4'hC);
    exp_pat_q.push_back(4'h8);
    exp_pat_q.push_back(4'h1);
    do_run(40);
    total_cnt++;
    if (to !== 1'b0) $display("FAIL basic_timeout got=%b want=0", to);
    else pass_cnt++;
    total_cnt++;
    if (cyc0 !== 7) $display("FAIL basic_latency got=%0d want=7", cyc0);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() !== 5)
      $display("FAIL basic_npat got=%0d want=5", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      p = exp_pat_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : 4'hx;
      total_cnt++;
      if (o !== p) $display("FAIL basic_pat%0d got=%h want=%h", i, o, p);
      else pass_cnt++;
    end
    e = exp_sig_q.pop_front();
    total_cnt++;
    if (sig0 !== e) $display("FAIL basic_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (pf0 !== 1'b1) $display("FAIL basic_pass got=%b want=1", pf0);
    else pass_cnt++;
  endtask

  task automatic test_lfsr;
    logic [3:0] p, o;
    lfsr_seed = 4'h0;
    test_len = 16'd3;
    do_run(40);
    o = (obs_q.size() > 0) ? obs_q[0] : 4'hx;
    total_cnt++;
    if (o !== 4'hF) $display("FAIL lockup_guard got=%h want=f", o);
    else pass_cnt++;
    lfsr_seed = 4'hF;
    test_len = 16'd16;
    for (int i = 0; i < 16; i++) exp_pat_q.push_back(m_pat(4'hF, i));
    do_run(60);
    total_cnt++;
    if (obs_q.size() !== 16)
      $display("FAIL period_npat got=%0d want=16", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      p = exp_pat_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : 4'hx;
      total_cnt++;
      if (o !== p) $display("FAIL period_pat%0d got=%h want=%h", i, o, p);
      else pass_cnt++;
    end
    o = (obs_q.size() > 15) ? obs_q[15] : 4'hx;
    total_cnt++;
    if (o !== 4'hF) $display("FAIL period_wrap got=%h want=f", o);
    else pass_cnt++;
  endtask

  task automatic test_golden;
    logic [7:0] e;
    lfsr_seed = 4'hF;
    test_len = 16'd5;
    golden_sig = m_sig(4'hF, 5, 4'h0) ^ 8'h01;
    exp_sig_q.push_back(m_sig(4'hF, 5, 4'h0));
    do_run(40);
    e = exp_sig_q.pop_front();
    total_cnt++;
    if (sig0 !== e) $display("FAIL badgold_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (pf0 !== 1'b0) $display("FAIL badgold_pf got=%b want=0", pf0);
    else pass_cnt++;
    golden_sig = m_sig(4'hF, 5, 4'h0);
    stuck = 4'b0100;
    exp_sig_q.push_back(m_sig(4'hF, 5, 4'b0100));
    do_run(40);
    e = exp_sig_q.pop_front();
    total_cnt++;
    if (sig0 !== e) $display("FAIL stuck_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (pf0 !== 1'b0) $display("FAIL stuck_pf got=%b want=0", pf0);
    else pass_cnt++;
    stuck = 4'h0;
  endtask

  task automatic test_latency;
    logic [7:0] e;
    lfsr_seed = 4'hF;
    test_len = 16'd10;
    golden_sig = m_sig(4'hF, 10, 4'h0);
    exp_sig_q.push_back(m_sig(4'hF, 10, 4'h0));
    do_run(60);
    e = exp_sig_q.pop_front();
    total_cnt++;
    if (to !== 1'b0) $display("FAIL lat_timeout got=%b want=0", to);
    else pass_cnt++;
    total_cnt++;
    if (cyc0 !== 12) $display("FAIL lat0_cycles got=%0d want=12", cyc0);
    else pass_cnt++;
    total_cnt++;
    if (cyc1 !== 14) $display("FAIL lat2_cycles got=%0d want=14", cyc1);
    else pass_cnt++;
    total_cnt++;
    if (sig0 !== e) $display("FAIL lat0_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (sig1 !== e) $display("FAIL lat2_sig got=%h want=%h", sig1, e);
    else pass_cnt++;
    total_cnt++;
    if (pf1 !== 1'b1) $display("FAIL lat2_pass got=%b want=1", pf1);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [7:0] prev, e;
    prev = m_sig(4'hF, 10, 4'h0);
    lfsr_seed = 4'hF;
    test_len = 16'd8;
    golden_sig = m_sig(4'hF, 8, 4'h0);
    @(negedge clk) bist_start = 1'b0;
    @(negedge clk) bist_start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (cut_in0 !== 4'h8) $display("FAIL abort_run3_pat got=%h want=8", cut_in0);
    else pass_cnt++;
    @(negedge clk) bist_abort = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({busy0, end0, pf0} !== 3'b000)
      $display("FAIL abort_run_flags got=%b want=000", {busy0, end0, pf0});
    else pass_cnt++;
    total_cnt++;
    if (sig0 !== prev) $display("FAIL abort_run_sig got=%h want=%h", sig0, prev);
    else pass_cnt++;
    @(negedge clk) bist_abort = 1'b0;
    exp_sig_q.push_back(m_sig(4'hF, 8, 4'h0));
    do_run(60);
    e = exp_sig_q.pop_front();
    total_cnt++;
    if (sig0 !== e) $display("FAIL abort_rerun_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    total_cnt++;
    if (pf0 !== 1'b1) $display("FAIL abort_rerun_pf got=%b want=1", pf0);
    else pass_cnt++;
    @(negedge clk) bist_abort = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({end0, pf0} !== 2'b00)
      $display("FAIL abort_done_flags got=%b want=00", {end0, pf0});
    else pass_cnt++;
    total_cnt++;
    if (sig0 !== e) $display("FAIL abort_done_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    @(negedge clk) bist_abort = 1'b0;
  endtask

  task automatic test_reset_midrun;
    lfsr_seed = 4'hF;
    test_len = 16'd8;
    @(negedge clk) bist_start = 1'b0;
    @(negedge clk) bist_start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bist_start = 1'b0;
    #1;
    total_cnt++;
    if ({busy0, end0, pf0} !== 3'b000)
      $display("FAIL midrst_flags got=%b want=000", {busy0, end0, pf0});
    else pass_cnt++;
    total_cnt++;
    if (sig0 !== 8'h00) $display("FAIL midrst_sig got=%h want=00", sig0);
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    lfsr_seed = 4'hF;
    test_len = 16'd5;
    golden_sig = m_sig(4'hF, 5, 4'h0);
    exp_sig_q.push_back(m_sig(4'hF, 5, 4'h0));
    do_run(40);
    repeat (5) @(posedge clk);
    #1;
    e = exp_sig_q.pop_front();
    total_cnt++;
    if ({busy0, end0} !== 2'b01)
      $display("FAIL hold_noretrig got=%b want=01", {busy0, end0});
    else pass_cnt++;
    total_cnt++;
    if (sig0 !== e) $display("FAIL hold_sig got=%h want=%h", sig0, e);
    else pass_cnt++;
    for (int r = 0; r < 5; r++) begin
      exp_sig_q.push_back(m_sig(4'hF, 5, 4'h0));
      do_run(40);
      e = exp_sig_q.pop_front();
      total_cnt++;
      if (sig0 !== e || cyc0 !== 7)
        $display("FAIL b2b_run%0d got=%h/%0d want=%h/7", r, sig0, cyc0, e);
      else pass_cnt++;
    end
    test_len = 16'd0;
    golden_sig = 8'h00;
    do_run(40);
    total_cnt++;
    if (cyc0 !== 2) $display("FAIL len0_cycles got=%0d want=2", cyc0);
    else pass_cnt++;
    total_cnt++;
    if ({sig0, pf0} !== {8'h00, 1'b1})
      $display("FAIL len0_sig got=%h/%b want=00/1", sig0, pf0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lfsr();
    test_golden();
    test_latency();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
